// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencer for the E stage of the MIPS pipeline.
// Owns HI/LO and holds busy for a fixed latency while a MULT/DIV result is
// pending. The result is computed at the start edge and committed to HI/LO
// on the edge where busy falls.
// Optional feature macro: MDU_DIV_EN (DIV/DIVU implemented when defined).
// Handshake: start qualifies md_op for one cycle and is only honoured while
// IDLE; md_stall = md_use_D & (busy | start) keeps a following MDU op in D.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall,
    output logic        dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] p_hi_q, p_hi_d;
    logic [31:0] p_lo_q, p_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        inh_q, inh_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    // Signed and unsigned 64-bit products of the E-stage operands.
    always_comb begin
        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    end

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;

    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag, divisor, q_mag, r_mag;

    // Sign-magnitude divide: truncates toward zero, remainder follows dividend.
    // A zero divisor is replaced by 1 so the datapath stays defined; the
    // result is then discarded by the write-inhibit flag.
    always_comb begin
        rs_neg   = rs_val[31] & (md_op == 3'd2);
        rt_neg   = rt_val[31] & (md_op == 3'd2);
        rs_mag   = rs_neg ? (32'd0 - rs_val) : rs_val;
        rt_mag   = rt_neg ? (32'd0 - rt_val) : rt_val;
        div_zero = (rt_val == 32'd0);
        divisor  = div_zero ? 32'd1 : rt_mag;
        q_mag    = rs_mag / divisor;
        r_mag    = rs_mag % divisor;
        quot     = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = rs_neg ? (32'd0 - r_mag) : r_mag;
    end
`else
    localparam bit DIV_EN = 1'b0;

    // No divider: DIV/DIVU decode as no-ops.
    always_comb begin
        quot     = 32'd0;
        rem      = 32'd0;
        div_zero = 1'b0;
    end
`endif

    // Next-state logic: accept ops in IDLE, count down and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        inh_d   = inh_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd0: begin
                            {p_hi_d, p_lo_d} = prod_s;
                            cnt_d   = 4'(MULT_CYCLES);
                            inh_d   = 1'b0;
                            state_d = S_RUN;
                        end
                        3'd1: begin
                            {p_hi_d, p_lo_d} = prod_u;
                            cnt_d   = 4'(MULT_CYCLES);
                            inh_d   = 1'b0;
                            state_d = S_RUN;
                        end
                        3'd2, 3'd3: begin
                            if (DIV_EN) begin
                                p_hi_d  = rem;
                                p_lo_d  = quot;
                                cnt_d   = 4'(DIV_CYCLES);
                                inh_d   = div_zero;
                                state_d = S_RUN;
                            end
                        end
                        3'd4: hi_d = rs_val;
                        3'd5: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // start is ignored here; the hazard unit stalls it away.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!inh_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                    state_d = S_RUN == state_q ? S_IDLE : state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            inh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            inh_q   <= inh_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;
    assign md_stall  = md_use_D & (busy | start);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Testbench for md_unit_ctrl: directed cases plus randomized op stream,
// scored against a behavioural HI/LO model with a completion queue.
module tb_md_unit_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;
    logic        dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    int          exp_len_q[$];
    logic [31:0] m_hi, m_lo;

    // Clock and DUT.
    always #5 clk = ~clk;

    md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
        .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall),
        .dbg_state(dbg_state)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: architectural HI/LO effect and busy length of one op.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int len);
        longint sp, x, y, q, r;
        logic [63:0] up;
        len = 0;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = sp;
                len = MC;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = up;
                len = MC;
            end
            3'd2, 3'd3: begin
`ifdef MDU_DIV_EN
                len = DC;
                if (b != 32'd0) begin
                    if (op == 3'd2) begin
                        x = longint'($signed(a));
                        y = longint'($signed(b));
                    end else begin
                        x = longint'({32'd0, a});
                        y = longint'({32'd0, b});
                    end
                    q = x / y;
                    r = x % y;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
`endif
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Monitor: on each busy fall, pop the expected result and run length.
    int          run_len = 0;
    logic        busy_prev = 1'b0;
    logic [63:0] mon_e;
    int          mon_l;
    always @(negedge clk) begin
        if (!reset) begin
            run_len   = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy) run_len++;
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = exp_len_q.pop_front();
                    check32("done_hi", hi, mon_e[63:32]);
                    check32("done_lo", lo, mon_e[31:0]);
                    check32("busy_len", 32'(run_len), 32'(mon_l));
                end
                run_len = 0;
            end
            busy_prev = busy;
        end
    end

    // Wait (bounded) for busy to fall; afterwards an MFHI in D must not stall.
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
        end
        md_use_D = 1'b1;
        #1 check1("mf_no_stall", md_stall, 1'b0);
        md_use_D = 1'b0;
    endtask

    // Driver: issue one op now (caller sits just after a negedge).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d);
        int len;
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_use_D = use_d;
        #1 check1("stall_issue", md_stall, use_d);
        model_op(op, a, b, len);
        if (len > 0) begin
            exp_q.push_back({m_hi, m_lo});
            exp_len_q.push_back(len);
        end
        @(negedge clk);
        start = 1'b0; rs_val = $urandom; rt_val = $urandom; md_use_D = 1'b0;
        if (len > 0) begin
            check1("busy_after_start", busy, 1'b1);
            wait_idle();
        end else begin
            check1("busy_stays_low", busy, 1'b0);
            check32("imm_hi", hi, m_hi);
            check32("imm_lo", lo, m_lo);
        end
    endtask

    logic [31:0] ra, rb;
    int          dummy_len;

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
        md_use_D = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        #12;
        check1("rst_busy", busy, 1'b0);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        check1("rst_stall", md_stall, 1'b0);
        md_use_D = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
        check32("mult_hi", hi, 32'hFFFFFFFF);
        check32("mult_lo", lo, 32'hFFFFFFF1);
        issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        check32("multu_hi", hi, 32'h00000001);
        check32("multu_lo", lo, 32'hFFFFFFFE);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
`ifdef MDU_DIV_EN
        check32("div_hi", hi, 32'hFFFFFFFF);
        check32("div_lo", lo, 32'hFFFFFFFD);
`else
        check32("nodiv_hi", hi, 32'h00000001);
        check32("nodiv_lo", lo, 32'hFFFFFFFE);
`endif
        issue(3'd4, 32'h12345678, 32'd0, 1'b0);
        issue(3'd5, 32'h9ABCDEF0, 32'd0, 1'b0);
        issue(3'd3, 32'd7, 32'd0, 1'b0);
        check32("div0_hi", hi, 32'h12345678);
        check32("div0_lo", lo, 32'h9ABCDEF0);

        // Stall window with md_use_D held, plus an illegal mid-RUN start.
        start = 1'b1; md_op = 3'd0; rs_val = 32'd7; rt_val = 32'd9; md_use_D = 1'b1;
        #1 check1("stall_t0", md_stall, 1'b1);
        model_op(3'd0, 32'd7, 32'd9, dummy_len);
        exp_q.push_back({m_hi, m_lo});
        exp_len_q.push_back(MC);
        for (int i = 1; i <= MC; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin
                md_op = 3'd1; rs_val = $urandom; rt_val = $urandom;
            end else begin
                rs_val = $urandom; rt_val = $urandom;
            end
            #1;
            check1("stall_run", md_stall, 1'b1);
            check1("busy_run", busy, 1'b1);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check1("stall_after", md_stall, 1'b0);
        check1("busy_after", busy, 1'b0);
        check32("ignored_hi", hi, 32'd0);
        check32("ignored_lo", lo, 32'd63);
        md_use_D = 1'b0;

        // Asynchronous reset in busy cycle 3 of a MULT.
        start = 1'b1; md_op = 3'd0; rs_val = 32'h00010000; rt_val = 32'h00030000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check1("pre_reset_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check1("areset_busy", busy, 1'b0);
        check32("areset_hi", hi, 32'd0);
        check32("areset_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        #1 reset = 1'b1;
        issue(3'd5, 32'h00000055, 32'd0, 1'b0);
        check32("mtlo_after_reset", lo, 32'h00000055);

        // Randomized legal op stream.
        for (int k = 0; k < 40; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            issue(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Multiply/divide unit sequencer for the 5-stage MIPS pipeline. Sits in the E stage beside the ALU; accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and owns the HI/LO registers. Holds `busy` for a fixed multi-cycle latency. Produces the MDU stall term that the hazard controller ORs into the D-stage `Stall`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU, range 1..15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU, range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is an MDU op; qualifies `md_op`.
- `md_op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
- `rs_val`  in  32  forwarded rs operand from E.
- `rt_val`  in  32  forwarded rt operand from E.
- `md_use_D`  in  1  D-stage instruction is any MDU op, including MFHI/MFLO.
- `busy`  out  1  registered; an operation is in flight.
- `hi`  out  32  registered HI.
- `lo`  out  32  registered LO.
- `md_stall`  out  1  combinational: `md_use_D & (busy | start)`.

## Operation
- FSM states: IDLE and RUN. A 4-bit down-counter `cnt` and 32-bit pending registers `p_hi`/`p_lo` are internal.
- **IDLE, start with md_op 0–3:**
  - Compute the result from `rs_val`/`rt_val` on this edge.
  - MULT is a signed 64-bit product and MULTU is unsigned; the result goes to {p_hi, p_lo}.
  - DIV/DIVU give quotient to p_lo and remainder to p_hi; DIV truncates toward zero and the remainder takes the sign of the dividend.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES and go to RUN.
- **IDLE, start with md_op 4 (MTHI):** `hi <= rs_val` on the edge; stays IDLE. **md_op 5 (MTLO):** `lo <= rs_val` the same way.
- **IDLE, start with md_op 6–7:** ignored.
- **RUN:** `cnt` decrements each cycle. On the edge where `cnt==1`:
  - `hi <= p_hi`, `lo <= p_lo`;
  - return to IDLE.
- **Divide by zero (`rt_val==0`, DIV or DIVU):**
  - Still runs the full DIV_CYCLES with `busy` high.
  - HI and LO are left unchanged at completion (a write-inhibit flag is latched at start).
- **`start` while RUN:** ignored, with no effect on state, counter or HI/LO. The hazard controller must prevent this via `md_stall`; the bench asserts it never happens under legal sequencing.
- `md_stall` uses `start` as well as `busy`, so an MDU op in D directly behind an MDU op in E stalls in the issue cycle.
- Reset at any time, including mid-RUN: state goes to IDLE; `cnt`, `p_hi`, `p_lo`, `hi`, `lo` become 0; `busy` becomes 0. Any in-flight result is discarded.

## Timing
- Reset values: `busy=0`, `hi=0`, `lo=0`; `md_stall` follows its inputs.
- Start accepted at edge T0:
  - `busy` is high from T0 to T0+N, where N = MULT_CYCLES or DIV_CYCLES, i.e. exactly N cycles;
  - HI/LO change at edge T0+N, the same edge at which `busy` falls.
- An MFHI in D during cycle T0+N (after that edge) reads the new value with no stall.
- A back-to-back start is legal at edge T0+N+1 at the earliest; this is the first cycle the block is IDLE.
- MTHI/MTLO: 1-cycle latency, `busy` never asserts.
- Operands are sampled only at the start edge. Later changes on `rs_val`/`rt_val` have no effect.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as described.
- `MDU_DIV_EN` undefined:
  - no divider logic is synthesized;
  - md_op 2/3 are treated as no-op: `busy` stays 0 and HI/LO are unchanged;
  - `DIV_CYCLES` is unused.
- MULT/MULTU/MTHI/MTLO behave identically in both builds.

## Test plan
- Reset released, then MULT rs=0xFFFFFFFD (−3), rt=5 → `busy` high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=0xFFFFFFFF, rt=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=2 with MDU_DIV_EN → `busy` 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=7, rt=0 after MTHI 0x12345678 and MTLO 0x9ABCDEF0 → `busy` 10 cycles; hi/lo remain 0x12345678/0x9ABCDEF0.
- MULT start with `md_use_D=1` held → `md_stall=1` in the start cycle and all 5 busy cycles, 0 in the next cycle. A second start pulsed mid-RUN is ignored and HI/LO equal the first result.
- Reset asserted at busy cycle 3 of a MULT → `busy`, hi, lo = 0 immediately (asynchronous). After release, MTLO 0x55 gives lo=0x55 one edge later.
